// File: rtl/riscv_wb_pkg.sv
// Shared types and constants for the register-file write-back path.
package riscv_wb_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NREGS      = 2 ** REG_ADDR_W;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_req_t;

    typedef enum logic {
        GNT_A = 1'b0,
        GNT_B = 1'b1
    } grant_t;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Bus bundle for the write-back arbiter: two requesters, register-file write
// port, issue reservation handshake and source busy lookups.
interface regfile_wb_arbiter_if;
    import riscv_wb_pkg::*;

    logic                  a_valid;
    logic                  a_ready;
    logic [REG_ADDR_W-1:0] a_rd;
    logic [XLEN-1:0]       a_data;

    logic                  b_valid;
    logic                  b_ready;
    logic [REG_ADDR_W-1:0] b_rd;
    logic [XLEN-1:0]       b_data;

    logic                  rf_regwrite;
    logic [REG_ADDR_W-1:0] rf_rd;
    logic [XLEN-1:0]       rf_wdata;

    logic                  issue_valid;
    logic [REG_ADDR_W-1:0] issue_rd;
    logic                  issue_ready;

    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
    logic                  busy_rs1;
    logic                  busy_rs2;

    modport master (
        output a_valid, a_rd, a_data,
        output b_valid, b_rd, b_data,
        output issue_valid, issue_rd, rs1, rs2,
        input  a_ready, b_ready,
        input  rf_regwrite, rf_rd, rf_wdata,
        input  issue_ready, busy_rs1, busy_rs2
    );

    modport slave (
        input  a_valid, a_rd, a_data,
        input  b_valid, b_rd, b_data,
        input  issue_valid, issue_rd, rs1, rs2,
        output a_ready, b_ready,
        output rf_regwrite, rf_rd, rf_wdata,
        output issue_ready, busy_rs1, busy_rs2
    );

endinterface

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin grant; last_grant moves only when a grant is
// actually accepted, so an idle cycle does not disturb the fairness order.
module rr_arbiter2
    import riscv_wb_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic req_a,
    input  logic req_b,
    input  logic accept,
    output logic gnt_a,
    output logic gnt_b
);

    grant_t last_grant_reg;

    always_comb begin
        gnt_a = req_a && (!req_b || (last_grant_reg == GNT_B));
        gnt_b = req_b && !gnt_a;
    end

    // Reset to B so A wins the first conflict.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_reg <= GNT_B;
        end else if (accept) begin
            last_grant_reg <= gnt_a ? GNT_A : GNT_B;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter for the register file's single write port.
// Optional pending-write scoreboard enabled by REGFILE_WB_SCOREBOARD_EN.
module regfile_wb_arbiter
    import riscv_wb_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    regfile_wb_arbiter_if.slave  bus
);

    wb_req_t req_a;
    wb_req_t req_b;
    wb_req_t win;
    logic    gnt_a;
    logic    gnt_b;
    logic    xfer;

    logic                  rf_regwrite_reg;
    logic [REG_ADDR_W-1:0] rf_rd_reg;
    logic [XLEN-1:0]       rf_wdata_reg;

    always_comb begin
        req_a = '{valid: bus.a_valid, rd: bus.a_rd, data: bus.a_data};
        req_b = '{valid: bus.b_valid, rd: bus.b_rd, data: bus.b_data};
        win   = gnt_a ? req_a : req_b;
        xfer  = gnt_a || gnt_b;
    end

    rr_arbiter2 u_arb (
        .clk    (clk),
        .rst    (rst),
        .req_a  (req_a.valid),
        .req_b  (req_b.valid),
        .accept (xfer),
        .gnt_a  (gnt_a),
        .gnt_b  (gnt_b)
    );

    // Output stage never stalls, so a grant is always a transfer.
    assign bus.a_ready = gnt_a;
    assign bus.b_ready = gnt_b;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_regwrite_reg <= 1'b0;
            rf_rd_reg       <= '0;
            rf_wdata_reg    <= '0;
        end else if (xfer) begin
            rf_regwrite_reg <= (win.rd != '0);
            rf_rd_reg       <= win.rd;
            rf_wdata_reg    <= win.data;
        end else begin
            rf_regwrite_reg <= 1'b0;
        end
    end

    assign bus.rf_regwrite = rf_regwrite_reg;
    assign bus.rf_rd       = rf_rd_reg;
    assign bus.rf_wdata    = rf_wdata_reg;

`ifdef REGFILE_WB_SCOREBOARD_EN
    logic [NREGS-1:0] pending_reg;
    logic [NREGS-1:0] pending_next;
    logic             issue_fire;

    assign bus.issue_ready = !pending_reg[bus.issue_rd] || (bus.issue_rd == '0);
    assign issue_fire      = bus.issue_valid && bus.issue_ready && (bus.issue_rd != '0);

    // Clear follows the register-file capture edge; a same-edge reservation wins.
    for (genvar gi = 0; gi < NREGS; gi++) begin : g_pending
        assign pending_next[gi] =
            (issue_fire && (bus.issue_rd == REG_ADDR_W'(gi))) ? 1'b1 :
            (rf_regwrite_reg && (rf_rd_reg == REG_ADDR_W'(gi))) ? 1'b0 :
            pending_reg[gi];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_reg <= '0;
        end else begin
            pending_reg <= pending_next;
        end
    end

    assign bus.busy_rs1 = pending_reg[bus.rs1];
    assign bus.busy_rs2 = pending_reg[bus.rs2];
`else
    wire unused_issue = ^{bus.issue_valid, bus.issue_rd, bus.rs1, bus.rs2};

    assign bus.issue_ready = 1'b1;
    assign bus.busy_rs1    = 1'b0;
    assign bus.busy_rs2    = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter; scoreboard-dependent checks
// follow REGFILE_WB_SCOREBOARD_EN.
module tb_regfile_wb_arbiter;
    import riscv_wb_pkg::*;

    logic clk;
    logic rst;

    regfile_wb_arbiter_if bus_if ();

    regfile_wb_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic                  regwrite;
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } exp_t;

    exp_t   exp_q[$];
    int     n_cmp = 0;
    int     n_err = 0;
    grant_t m_last = GNT_B;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, obs);
        end
    endtask

    // Starts and ends on a falling edge; drives one cycle of requests.
    task automatic drive_cycle(
        input  logic                  av,
        input  logic [REG_ADDR_W-1:0] ard,
        input  logic [XLEN-1:0]       ad,
        input  logic                  bv,
        input  logic [REG_ADDR_W-1:0] brd,
        input  logic [XLEN-1:0]       bd,
        output logic                  granted_a
    );
        logic ga;
        logic gb;
        exp_t e;
        exp_t got;
        bus_if.a_valid = av;
        bus_if.a_rd    = ard;
        bus_if.a_data  = ad;
        bus_if.b_valid = bv;
        bus_if.b_rd    = brd;
        bus_if.b_data  = bd;
        ga = av && (!bv || (m_last == GNT_B));
        gb = bv && !ga;
        #1;
        check("a_ready", 64'(bus_if.a_ready), 64'(ga));
        check("b_ready", 64'(bus_if.b_ready), 64'(gb));
        e.regwrite = 1'b0;
        e.rd       = '0;
        e.data     = '0;
        if (ga) begin
            e.regwrite = (ard != '0);
            e.rd       = ard;
            e.data     = ad;
            m_last     = GNT_A;
        end else if (gb) begin
            e.regwrite = (brd != '0);
            e.rd       = brd;
            e.data     = bd;
            m_last     = GNT_B;
        end
        exp_q.push_back(e);
        granted_a = ga;
        @(posedge clk);
        #1;
        check("sb_queue_nonempty", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
            got = exp_q.pop_front();
            check("rf_regwrite", 64'(bus_if.rf_regwrite), 64'(got.regwrite));
            if (got.regwrite) begin
                check("rf_rd", 64'(bus_if.rf_rd), 64'(got.rd));
                check("rf_wdata", 64'(bus_if.rf_wdata), 64'(got.data));
            end
        end
        @(negedge clk);
    endtask

    task automatic idle_cycle();
        logic dummy;
        drive_cycle(1'b0, '0, '0, 1'b0, '0, '0, dummy);
    endtask

    logic ga;
    logic [REG_ADDR_W-1:0] a_idx;
    logic exp_order [4];

    initial begin
        exp_order[0] = 1'b1;
        exp_order[1] = 1'b0;
        exp_order[2] = 1'b1;
        exp_order[3] = 1'b0;

        rst                = 1'b1;
        bus_if.a_valid     = 1'b0;
        bus_if.a_rd        = '0;
        bus_if.a_data      = '0;
        bus_if.b_valid     = 1'b0;
        bus_if.b_rd        = '0;
        bus_if.b_data      = '0;
        bus_if.issue_valid = 1'b0;
        bus_if.issue_rd    = '0;
        bus_if.rs1         = 5'd7;
        bus_if.rs2         = 5'd3;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_regwrite", 64'(bus_if.rf_regwrite), 64'd0);
        check("rst_rf_rd", 64'(bus_if.rf_rd), 64'd0);
        check("rst_rf_wdata", 64'(bus_if.rf_wdata), 64'd0);
        check("rst_a_ready", 64'(bus_if.a_ready), 64'd0);
        check("rst_b_ready", 64'(bus_if.b_ready), 64'd0);
        check("rst_issue_ready", 64'(bus_if.issue_ready), 64'd1);
        check("rst_busy_rs1", 64'(bus_if.busy_rs1), 64'd0);
        check("rst_busy_rs2", 64'(bus_if.busy_rs2), 64'd0);

        // Single A write, then an idle cycle returns regwrite to 0.
        drive_cycle(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, '0, '0, ga);
        idle_cycle();

        // B write to x0: accepted, no register-file write.
        drive_cycle(1'b0, '0, '0, 1'b1, 5'd0, 32'h1234, ga);
        check("x0_busy_rs2", 64'(bus_if.busy_rs2), 64'd0);

        // Continuous conflict: A advances rd on each grant, B holds rd=9.
        a_idx = 5'd1;
        for (int i = 0; i < 4; i++) begin
            drive_cycle(1'b1, a_idx, 32'hA000_0000 | 32'(a_idx), 1'b1, 5'd9, 32'hB000_0009, ga);
            check("conflict_gnt_a", 64'(ga), 64'(exp_order[i]));
            if (ga) a_idx = a_idx + 5'd1;
        end
        idle_cycle();

`ifdef REGFILE_WB_SCOREBOARD_EN
        bus_if.rs1         = 5'd7;
        bus_if.issue_valid = 1'b1;
        bus_if.issue_rd    = 5'd7;
        #1;
        check("issue7_ready", 64'(bus_if.issue_ready), 64'd1);
        @(negedge clk);
        check("issue7_busy", 64'(bus_if.busy_rs1), 64'd1);
        check("waw_issue_ready", 64'(bus_if.issue_ready), 64'd0);
        @(negedge clk);
        bus_if.issue_valid = 1'b0;
        drive_cycle(1'b1, 5'd7, 32'h7777_0007, 1'b0, '0, '0, ga);
        check("busy_while_committing", 64'(bus_if.busy_rs1), 64'd1);
        idle_cycle();
        check("busy_cleared", 64'(bus_if.busy_rs1), 64'd0);
        // Unreserved write to 7, then reserve 7 on its clearing edge.
        drive_cycle(1'b1, 5'd7, 32'h7777_0008, 1'b0, '0, '0, ga);
        bus_if.issue_valid = 1'b1;
        bus_if.issue_rd    = 5'd7;
        idle_cycle();
        bus_if.issue_valid = 1'b0;
        check("set_wins_busy", 64'(bus_if.busy_rs1), 64'd1);
        bus_if.issue_valid = 1'b1;
        bus_if.issue_rd    = 5'd3;
        idle_cycle();
        bus_if.issue_valid = 1'b0;
        check("issue3_busy", 64'(bus_if.busy_rs2), 64'd1);
`else
        bus_if.issue_valid = 1'b1;
        bus_if.issue_rd    = 5'd7;
        #1;
        check("nosb_issue_ready", 64'(bus_if.issue_ready), 64'd1);
        idle_cycle();
        bus_if.issue_valid = 1'b0;
        bus_if.rs1         = 5'd7;
        #1;
        check("nosb_busy_rs1", 64'(bus_if.busy_rs1), 64'd0);
`endif

        // Reset while a write to x3 is registered but not yet committed.
        drive_cycle(1'b1, 5'd3, 32'h3333_3333, 1'b0, '0, '0, ga);
        bus_if.a_valid = 1'b0;
        rst = 1'b1;
        m_last = GNT_B;
        #1;
        check("midrst_regwrite", 64'(bus_if.rf_regwrite), 64'd0);
        check("midrst_rf_rd", 64'(bus_if.rf_rd), 64'd0);
        check("midrst_busy_rs1", 64'(bus_if.busy_rs1), 64'd0);
        check("midrst_busy_rs2", 64'(bus_if.busy_rs2), 64'd0);
        check("midrst_issue_ready", 64'(bus_if.issue_ready), 64'd1);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        drive_cycle(1'b1, 5'd11, 32'hAAAA_0011, 1'b1, 5'd12, 32'hBBBB_0012, ga);
        check("post_rst_first_conflict_a", 64'(ga), 64'd1);
        drive_cycle(1'b1, 5'd13, 32'hAAAA_0013, 1'b1, 5'd12, 32'hBBBB_0012, ga);
        check("post_rst_second_conflict_b", 64'(ga), 64'd0);
        idle_cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
